// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, I/O address and state type for the memory responder
package mem_pkg;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam logic [ADDR_W-1:0] IO_ADDR = 8'hFF;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      LOAD  = 2'd1,
      SERVE = 2'd2
   } memstate_t;
endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - DEPTH x 8 storage, asynchronous read port, synchronous write port
module mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];

   // single write port; the top level decides which source owns it each cycle
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CPU memory responder with clear/load front end; MEM_IO_PORT_EN maps 8'hFF to an I/O port
module mem_responder
   import mem_pkg::*;
#(
   parameter int                DEPTH     = 256,
   parameter logic [DATA_W-1:0] CLEAR_VAL = 8'h00
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] mar,
   input  logic              we,
   inout  wire  [DATA_W-1:0] mbr,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_wrap,
   output logic              cpu_reset,
   input  logic [DATA_W-1:0] io_in,
   output logic [DATA_W-1:0] io_out
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   memstate_t         state;
   memstate_t         state_n;
   logic [ADDR_W-1:0] cnt;
   logic              accept;
   logic              io_hit;
   logic              drive_en;
   logic              arr_wr_en;
   logic [ADDR_W-1:0] arr_wr_addr;
   logic [DATA_W-1:0] arr_wr_data;
   logic [DATA_W-1:0] arr_rd_data;
   logic [DATA_W-1:0] rd_data;

`ifdef MEM_IO_PORT_EN
   assign io_hit  = (mar == IO_ADDR);
   assign rd_data = io_hit ? io_in : arr_rd_data;

   // io_out survives CLEAR; only reset or a CPU store to the port changes it
   always_ff @(posedge clock) begin
      if (reset) begin
         io_out <= '0;
      end else if (state == SERVE && we && io_hit) begin
         io_out <= mbr;
      end
   end
`else
   logic unused_io_in;
   assign unused_io_in = ^io_in;
   assign io_hit       = 1'b0;
   assign rd_data      = arr_rd_data;
   assign io_out       = '0;
`endif

   mem_array #(
      .DEPTH(DEPTH)
   ) u_array (
      .clock  (clock),
      .wr_en  (arr_wr_en),
      .wr_addr(arr_wr_addr),
      .wr_data(arr_wr_data),
      .rd_addr(mar),
      .rd_data(arr_rd_data)
   );

   // state register; reset from any state restarts the clear sweep
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= CLEAR;
      end else begin
         state <= state_n;
      end
   end

   // next state, loader handshake and write-port source selection
   always_comb begin
      state_n     = state;
      load_ready  = 1'b0;
      accept      = 1'b0;
      arr_wr_en   = 1'b0;
      arr_wr_addr = cnt;
      arr_wr_data = CLEAR_VAL;
      case (state)
         CLEAR: begin
            arr_wr_en = 1'b1;
            if (cnt == LAST_ADDR) begin
               state_n = LOAD;
            end
         end
         LOAD: begin
            load_ready  = 1'b1;
            accept      = load_valid;
            arr_wr_en   = load_valid;
            arr_wr_data = load_data;
            if (load_valid && load_last) begin
               state_n = SERVE;
            end
         end
         SERVE: begin
            arr_wr_en   = we && !io_hit;
            arr_wr_addr = mar;
            arr_wr_data = mbr;
            if (load_start) begin
               state_n = CLEAR;
            end
         end
         default: begin
            state_n = CLEAR;
         end
      endcase
      if (reset) begin
         arr_wr_en = 1'b0;
      end
   end

   // address counter, sticky wrap flag and registered CPU reset
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt       <= '0;
         load_wrap <= 1'b0;
         cpu_reset <= 1'b1;
      end else begin
         cpu_reset <= (state_n != SERVE);
         case (state)
            CLEAR: begin
               cnt <= cnt + 8'd1;
            end
            LOAD: begin
               if (accept) begin
                  cnt <= cnt + 8'd1;
                  if (cnt == LAST_ADDR) begin
                     load_wrap <= 1'b1;
                  end
               end
            end
            SERVE: begin
               if (load_start) begin
                  cnt       <= '0;
                  load_wrap <= 1'b0;
               end
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

   // bus drive only when the CPU is running and reading
   assign drive_en = (state == SERVE) && !we;
   assign mbr      = drive_en ? rd_data : 'z;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder against a behavioural memory model
module tb_mem_responder;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] mar = 8'h00;
   logic       we = 1'b0;
   wire  [7:0] mbr;
   logic [7:0] tb_mbr = 8'h00;
   logic       load_start = 1'b0;
   logic       load_valid = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic       load_last = 1'b0;
   logic       load_ready;
   logic       load_wrap;
   logic       cpu_reset;
   logic [7:0] io_in = 8'h00;
   logic [7:0] io_out;

   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] model_mem [256];
   logic [7:0] model_io_out = 8'h00;
   int         model_addr = 0;
   logic       model_wrap = 1'b0;

   always #5 clock = ~clock;

   assign mbr = we ? tb_mbr : 8'hzz;

   mem_responder dut (
      .clock     (clock),
      .reset     (reset),
      .mar       (mar),
      .we        (we),
      .mbr       (mbr),
      .load_start(load_start),
      .load_valid(load_valid),
      .load_data (load_data),
      .load_last (load_last),
      .load_ready(load_ready),
      .load_wrap (load_wrap),
      .cpu_reset (cpu_reset),
      .io_in     (io_in),
      .io_out    (io_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
      model_addr = 0;
      model_wrap = 1'b0;
   endtask

   task automatic check_all_mem(input string tag);
      for (int i = 0; i < 256; i++) check(tag, dut.u_array.mem[i], model_mem[i]);
   endtask

   task automatic wait_clear();
      for (int i = 0; i < 256; i++) begin
         check("clear_cpu_reset", cpu_reset, 1);
         check("clear_not_ready", load_ready, 0);
         tick();
      end
      check("ready_after_clear", load_ready, 1);
      model_clear();
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
      int w;
      repeat (gap) tick();
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      w = 0;
      while (!load_ready && w < 300) begin
         tick();
         w++;
      end
      if (!load_ready) check("load_ready_timeout", 0, 1);
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      model_mem[model_addr] = d;
      if (model_addr == 255) model_wrap = 1'b1;
      model_addr = (model_addr + 1) % 256;
   endtask

   task automatic cpu_read(input logic [7:0] a);
      logic [7:0] exp;
      mar = a;
      we  = 1'b0;
      #1;
      exp = model_mem[a];
`ifdef MEM_IO_PORT_EN
      if (a == 8'hFF) exp = io_in;
`endif
      check("cpu_read", mbr, exp);
      tick();
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
      mar    = a;
      tb_mbr = d;
      we     = 1'b1;
      #1;
      check("no_drive_on_write", dut.drive_en, 0);
      tick();
      we = 1'b0;
`ifdef MEM_IO_PORT_EN
      if (a == 8'hFF) model_io_out = d;
      else model_mem[a] = d;
`else
      model_mem[a] = d;
`endif
   endtask

   task automatic reload();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check("reload_cpu_reset", cpu_reset, 1);
      check("reload_wrap_clear", load_wrap, 0);
      check("reload_not_ready", load_ready, 0);
   endtask

   initial begin
      model_clear();
      tick();
      tick();
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_load_ready", load_ready, 0);
      check("rst_load_wrap", load_wrap, 0);
      check("rst_io_out", io_out, 8'h00);
      check("rst_no_drive", dut.drive_en, 0);
      reset = 1'b0;
      wait_clear();
      check_all_mem("clear_mem");

      send_byte(8'h41, 1'b0, 0);
      send_byte(8'h52, 1'b0, 2);
      check("cpu_reset_before_last", cpu_reset, 1);
      send_byte(8'h30, 1'b1, 2);
      check("cpu_reset_after_last", cpu_reset, 0);
      check("serve_not_ready", load_ready, 0);
      check("mem0", dut.u_array.mem[0], 8'h41);
      check("mem1", dut.u_array.mem[1], 8'h52);
      check("mem2", dut.u_array.mem[2], 8'h30);

      cpu_read(8'h01);
      cpu_write(8'hF3, 8'h7C);
      tick();
      cpu_read(8'hF3);

      for (int i = 0; i < 80; i++) begin
         io_in = 8'($urandom);
         if ($urandom_range(0, 1) == 1) cpu_write(8'($urandom), 8'($urandom));
         else cpu_read(8'($urandom));
      end
      check("io_out_after_random", io_out, model_io_out);

      reload();
      wait_clear();
      for (int i = 0; i < 258; i++) send_byte(8'(i + 1), i == 257, $urandom_range(0, 1));
      check("wrap_set", load_wrap, model_wrap);
      check("wrap_mem0", dut.u_array.mem[0], 8'h01);
      check("wrap_mem1", dut.u_array.mem[1], 8'h02);
      check("wrap_mem255", dut.u_array.mem[255], 8'h00);
      check_all_mem("wrap_image");
      for (int i = 0; i < 10; i++) cpu_read(8'($urandom));

      reload();
      wait_clear();
      for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(1, 255)), 1'b0, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midload_rst_cpu_reset", cpu_reset, 1);
      check("midload_rst_not_ready", load_ready, 0);
      wait_clear();
      check_all_mem("midload_rst_mem");

      for (int i = 0; i < 4; i++) send_byte(8'($urandom), i == 3, 0);
      check("serve_again", cpu_reset, 0);
`ifdef MEM_IO_PORT_EN
      cpu_write(8'hFF, 8'hA5);
      check("io_out_write", io_out, 8'hA5);
      io_in = 8'h3C;
      cpu_read(8'hFF);
      reload();
      check("io_out_hold_reload", io_out, 8'hA5);
      wait_clear();
      check("io_out_hold_clear", io_out, 8'hA5);
`else
      cpu_write(8'hFF, 8'hA5);
      check("io_out_tied", io_out, 8'h00);
      cpu_read(8'hFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
